arbitro_escritura: RTL and testbench
====================================

ARBITRO_ESCRITURA -- requirements
Module: arbitro_escritura

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK (rising edge) and RST.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the LSU writeback buffer depth.
REQ-004 Port CLK  input  1  clock.
REQ-005 Port RST  input  1  asynchronous active-high reset.
REQ-006 Ports alu_valid / alu_rd / alu_data  input  1 / 5 / DATA_W  single-cycle ALU writeback request, no backpressure.
REQ-007 Ports lsu_valid / lsu_rd / lsu_data  input  1 / 5 / DATA_W  load/multi-cycle writeback request.
REQ-008 Port lsu_ready  output  1  LSU request accepted on an edge where lsu_valid and lsu_ready are both high.
REQ-009 Ports writeReg / writeData / RegWrite  output  5 / DATA_W / 1  registered write port to banco_registros.
REQ-010 Port alu_stall  output  1  asks the pipeline to hold its ALU writeback for one cycle.
REQ-011 Port pend_mask  output  32  bit r high while a buffered write to register r is pending.
REQ-012 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  current LSU buffer occupancy.

Function
REQ-013 ALU request (alu_valid=1, alu_rd!=0, alu_stall=0) in cycle N SHALL appear as RegWrite=1, writeReg=alu_rd, writeData=alu_data in cycle N+1.
REQ-014 An LSU handshake with lsu_rd!=0 SHALL push {lsu_rd, lsu_data} into the FIFO; an LSU handshake with lsu_rd=0 SHALL complete but SHALL NOT be stored.
REQ-015 lsu_ready SHALL be high iff the FIFO is not full; a pop in the same cycle SHALL NOT raise lsu_ready.
REQ-016 The FIFO head SHALL be popped and presented on the write port in the next cycle when no ALU grant occurs that cycle; minimum LSU latency SHALL be 2 cycles from handshake to RegWrite.
REQ-017 The ALU SHALL have priority over the FIFO head, except as defined in REQ-026.
REQ-018 An ALU request with alu_rd=0 SHALL be treated as no request and SHALL NOT block a FIFO pop.
REQ-019 RegWrite SHALL be 0 in any cycle with no grant; writeReg/writeData SHALL hold their last values.
REQ-020 RegWrite SHALL never be 1 with writeReg=0.
REQ-021 Simultaneous push and pop SHALL keep fifo_count unchanged and preserve FIFO order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 pend_mask SHALL be the combinational OR over valid FIFO entries of one-hot(rd); bit 0 SHALL always be 0.

Reset
REQ-023 While RST=1: FIFO emptied, fifo_count=0, lsu_ready=0, RegWrite=0, writeReg=0, writeData=0, alu_stall=0, pend_mask=0.
REQ-024 lsu_ready SHALL rise in the first cycle after RST deasserts; reset mid-operation SHALL discard all buffered writes without a RegWrite pulse.

Configuration
REQ-025 Macro ARB_ANTIHAMBRE_EN SHALL select the starvation policy.
REQ-026 With ARB_ANTIHAMBRE_EN defined: when the FIFO is full and alu_valid=1 with alu_rd!=0, alu_stall SHALL be high combinationally, the FIFO head SHALL be granted, and the ALU request SHALL be ignored that cycle.
REQ-027 Without ARB_ANTIHAMBRE_EN: alu_stall SHALL be tied to 0 and the ALU SHALL always win.

Structure
REQ-028 A shared package SHALL hold the register-index width (5), the x0 index constant, and the writeback-entry typedef {rd, data}.
REQ-029 The buffer SHALL be a sub-module fifo_escritura (push/pop/full/empty/count, entries visible for pend_mask).

Verification
REQ-030 ALU alu_rd=13, alu_data=32'h0000A234 in cycle N -> RegWrite=1, writeReg=13, writeData=32'h0000A234 in N+1; a banco_registros read of x13 then returns 32'h0000A234.
REQ-031 ALU alu_rd=0, alu_data=32'h000000A1 -> RegWrite stays 0; x0 reads 0.
REQ-032 LSU pushes rd=5,6,7,8 while ALU is valid every cycle with rd=1 -> lsu_ready=0 after the fourth push, pend_mask=32'h000001E0; with the macro the head (rd=5) is written with alu_stall=1; without it nothing drains until alu_valid drops.
REQ-033 alu_valid=0, LSU rd=9 data=32'hDEADBEEF handshake in cycle N -> RegWrite at N+2 with writeReg=9; pend_mask[9] high in N+1 only.
REQ-034 RST asserted with 3 entries buffered -> fifo_count=0, pend_mask=0, RegWrite=0 immediately, and no write after release.

Source files
------------

// File: rtl/arbitro_escritura_pkg.sv
// Shared types for the register-file write arbiter.
// Index width, x0 constant, writeback entry and pending-mask helper.
package arbitro_escritura_pkg;

  localparam int REG_W      = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W_DEF = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;

  typedef struct packed {
    reg_idx_t              rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // x0 never shows up as pending
  function automatic logic [NUM_REGS-1:0] rd_onehot(reg_idx_t rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = (rd != X0);
    return m;
  endfunction

endpackage

// File: rtl/arbitro_escritura_fifo.sv
// fifo_escritura: LSU writeback buffer with per-entry visibility
// so the arbiter can build the pending-register mask.
module fifo_escritura
  import arbitro_escritura_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  reg_idx_t             push_rd,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop,
  output reg_idx_t             head_rd,
  output logic [DATA_W-1:0]    head_data,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output reg_idx_t [DEPTH-1:0] ent_rd,
  output logic [DEPTH-1:0]     ent_valid
);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_W-1:0]    data_mem [DEPTH];
  reg_idx_t [DEPTH-1:0] rd_mem;
  logic                 do_push;
  logic                 do_pop;
  logic [AW-1:0]        off;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_mem <= '0;
    end else begin
      if (do_push) begin
        wr_ptr         <= wr_ptr + AW'(1);
        rd_mem[wr_ptr] <= push_rd;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      data_mem[wr_ptr] <= push_data;
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign ent_rd    = rd_mem;

  // slot i is live when its distance from the head is below count
  always_comb begin
    ent_valid = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = AW'(i) - rd_ptr;
      ent_valid[i] = ((AW+1)'(off) < count);
    end
  end

endmodule

// File: rtl/arbitro_escritura.sv
// Write-port arbiter: single-cycle ALU vs buffered LSU writebacks.
// Define ARB_ANTIHAMBRE_EN to let a full buffer stall the ALU.
module arbitro_escritura
  import arbitro_escritura_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        alu_valid,
  input  logic [REG_W-1:0]            alu_rd,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        lsu_valid,
  input  logic [REG_W-1:0]            lsu_rd,
  input  logic [DATA_W-1:0]           lsu_data,
  output logic                        lsu_ready,
  output logic [REG_W-1:0]            writeReg,
  output logic [DATA_W-1:0]           writeData,
  output logic                        RegWrite,
  output logic                        alu_stall,
  output logic [NUM_REGS-1:0]         pend_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  reg_idx_t                  head_rd;
  logic [DATA_W-1:0]         head_data;
  logic                      full;
  logic                      empty;
  reg_idx_t [FIFO_DEPTH-1:0] ent_rd;
  logic [FIFO_DEPTH-1:0]     ent_valid;
  logic                      alu_req;
  logic                      alu_grant;
  logic                      push;
  logic                      pop;

  assign alu_req = alu_valid & (alu_rd != X0);

`ifdef ARB_ANTIHAMBRE_EN
  assign alu_stall = alu_req & full;
`else
  assign alu_stall = 1'b0;
`endif

  assign alu_grant = alu_req & ~alu_stall;
  assign pop       = ~empty & ~alu_grant;
  assign lsu_ready = ~full & ~RST;
  assign push      = lsu_valid & lsu_ready & (lsu_rd != X0);

  fifo_escritura #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .ent_rd    (ent_rd),
    .ent_valid (ent_valid)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_valid[i])
        pend_mask = pend_mask | rd_onehot(ent_rd[i]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWrite  <= 1'b0;
      writeReg  <= X0;
      writeData <= '0;
    end else begin
      RegWrite <= alu_grant | pop;
      unique case (1'b1)
        alu_grant: begin
          writeReg  <= alu_rd;
          writeData <= alu_data;
        end
        pop: begin
          writeReg  <= head_rd;
          writeData <= head_data;
        end
        default: begin
          writeReg  <= writeReg;
          writeData <= writeData;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_escritura.sv
// Bench for arbitro_escritura: directed cases plus random traffic
// against a queue-based reference of the arbitration rules.
module tb_arbitro_escritura;
  import arbitro_escritura_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        RegWrite;
  logic        alu_stall;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;

  arbitro_escritura #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .RegWrite   (RegWrite),
    .alu_stall  (alu_stall),
    .pend_mask  (pend_mask),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  wb_entry_t   q[$];
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_dat;
  logic [31:0] rf [32];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // register file fed by the write port; x0 is hardwired
  always @(negedge clk) begin
    if (!rst && RegWrite === 1'b1) begin
      chk("wr_x0", {31'd0, writeReg != 5'd0}, 32'd1);
      if (writeReg != 5'd0)
        rf[writeReg] = writeData;
    end
  end

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic step(input logic av, input logic [4:0] ard,
                      input logic [31:0] adat, input logic lv,
                      input logic [4:0] lrd, input logic [31:0] ldat);
    int          n;
    logic        areq;
    logic        stl;
    logic [31:0] pm;
    wb_entry_t   ent;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    #1;
    n    = q.size();
    areq = av && (ard != 0);
`ifdef ARB_ANTIHAMBRE_EN
    stl = areq && (n == DEPTH);
`else
    stl = 1'b0;
`endif
    pm = 0;
    foreach (q[i]) pm |= (32'd1 << q[i].rd);
    chk("ready", {31'd0, lsu_ready}, {31'd0, n < DEPTH});
    chk("stall", {31'd0, alu_stall}, {31'd0, stl});
    chk("pend", pend_mask, pm);
    chk("count", {29'd0, fifo_count}, 32'(n));
    if (areq && !stl) begin
      e_we = 1; e_rd = ard; e_dat = adat;
    end else if (n > 0) begin
      ent  = q.pop_front();
      e_we = 1; e_rd = ent.rd; e_dat = ent.data;
    end else begin
      e_we = 0;
    end
    if (lv && n < DEPTH && lrd != 0) begin
      ent.rd = lrd; ent.data = ldat;
      q.push_back(ent);
    end
    @(posedge clk);
    #1;
    chk("regwrite", {31'd0, RegWrite}, {31'd0, e_we});
    chk("writereg", {27'd0, writeReg}, {27'd0, e_rd});
    chk("writedata", writeData, e_dat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst_stall", {31'd0, alu_stall}, 32'd0);
    chk("rst_wreg", {27'd0, writeReg}, 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    q.delete();
    e_we = 0; e_rd = 0; e_dat = 0;
    @(negedge clk);
    chk("rst_hold_regwrite", {31'd0, RegWrite}, 32'd0);
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    rst = 1;
    idle_inputs();
    e_we = 0; e_rd = 0; e_dat = 0;
    do_reset();

    // ALU write appears next cycle and lands in the register file
    step(1, 13, 32'h0000A234, 0, 0, 0);
    chk("alu13_we", {31'd0, RegWrite}, 32'd1);
    chk("alu13_rd", {27'd0, writeReg}, 32'd13);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rf_x13", rf[13], 32'h0000A234);

    // ALU to x0 is no request
    step(1, 0, 32'h000000A1, 0, 0, 0);
    chk("alu_x0_we", {31'd0, RegWrite}, 32'd0);
    chk("rf_x0", rf[0], 32'd0);

    // LSU latency two cycles, pending only in between
    step(0, 0, 0, 1, 9, 32'hDEADBEEF);
    chk("lsu9_pend", {31'd0, pend_mask[9]}, 32'd1);
    chk("lsu9_we_n1", {31'd0, RegWrite}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("lsu9_we_n2", {31'd0, RegWrite}, 32'd1);
    chk("lsu9_rd", {27'd0, writeReg}, 32'd9);
    chk("lsu9_pend_clr", {31'd0, pend_mask[9]}, 32'd0);

    // fill the buffer behind a busy ALU
    for (int k = 0; k < 4; k++)
      step(1, 1, 32'h100 + k, 1, 5'(5 + k), 32'h500 + k);
    chk("full_pend", pend_mask, 32'h000001E0);
    chk("full_ready", {31'd0, lsu_ready}, 32'd0);
    step(1, 1, 32'h104, 1, 10, 32'h50A);
`ifdef ARB_ANTIHAMBRE_EN
    chk("starve_rd", {27'd0, writeReg}, 32'd5);
`else
    chk("starve_rd", {27'd0, writeReg}, 32'd1);
    step(1, 1, 32'h105, 0, 0, 0);
    chk("starve_cnt", {29'd0, fifo_count}, 32'd4);
`endif
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0);

    // reset with three buffered entries
    for (int k = 0; k < 3; k++)
      step(1, 2, 32'h200 + k, 1, 5'(20 + k), 32'h700 + k);
    chk("pre_rst_cnt", {29'd0, fifo_count}, 32'd3);
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0);

    // random traffic: busy ALU phase then light ALU phase
    for (int k = 0; k < 500; k++) begin
      int pa;
      pa = (k < 250) ? 85 : 25;
      step($urandom_range(0, 99) < pa, 5'($urandom_range(0, 31)),
           $urandom, $urandom_range(0, 99) < 60,
           5'($urandom_range(0, 31)), $urandom);
    end
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
